alu16_seq: RTL

- Two-pass sequencer that runs the 16-bit SM83 arithmetic ops (ADD HL,rr / ADD SP,e8 / INC rr / DEC rr) through the existing 8-bit ALU.
- Sits beside the ALU in the CPU datapath and drives its operand, op and flag inputs for two consecutive cycles: low byte first, then high byte with carry chained.
- Consumes the ALU result and flags each pass, then presents one 16-bit result and the final ZNHC flag nibble to the register-file writeback.

---
 rtl/alu16_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu16_seq.sv
// alu16_seq: runs 16-bit SM83 ADD HL,rr / ADD SP,e8 / INC rr / DEC rr
// as two passes through the shared 8-bit ALU (low byte, then high byte).
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             op request, sampled only in IDLE
//   i_op16              0=ADD_HL 1=ADD_SP_E8 2=INC16 3=DEC16
//   i_operand_a/_b      16-bit sources (b[7:0]=e8 for ADD_SP_E8)
//   i_flags_in          current {Z,N,H,C}
//   o_busy, o_done      busy in LOW/HIGH, done pulse in DONE
//   o_result16          16-bit result, held until next done
//   o_flags_out         final {Z,N,H,C}, held until next done
//   o_alu_sel           this block owns the ALU inputs
//   o_alu_a/_b/_op      ALU operands and opcode
//   o_alu_flags_to      ALU flag input (carry chain)
//   i_alu_result        ALU result (combinational)
//   i_alu_flags_from    ALU flag output
`timescale 1ns/1ps
module alu16_seq #(
  parameter logic [4:0] OP_ADD = 5'b00000,
  parameter logic [4:0] OP_ADC = 5'b00001
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_op16,
  input  logic [15:0] i_operand_a,
  input  logic [15:0] i_operand_b,
  input  logic [3:0]  i_flags_in,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_result16,
  output logic [3:0]  o_flags_out,
  output logic        o_alu_sel,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic [4:0]  o_alu_op,
  output logic [3:0]  o_alu_flags_to,
  input  logic [7:0]  i_alu_result,
  input  logic [3:0]  i_alu_flags_from
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_ADD_HL = 2'd0;
  localparam logic [1:0] OP_ADD_SP = 2'd1;
  localparam logic [1:0] OP_INC16  = 2'd2;
  localparam logic [1:0] OP_DEC16  = 2'd3;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [3:0]  r_fin;
  logic [7:0]  r_res_lo;
  logic [1:0]  r_f_lo;
  logic [15:0] r_result;
  logic [3:0]  r_flags;

  logic [7:0]  w_b_lo;
  logic [7:0]  w_b_hi;
  logic [3:0]  w_flags_fin;
  logic        w_unused_zn;

  // Z/N from the ALU are never consumed: 16-bit Z comes from F or is 0.
  assign w_unused_zn = ^i_alu_flags_from[3:2];

  // DEC16 is an add of 0xFFFF so only ADD/ADC are ever issued.
  always_comb begin
    w_b_lo = 8'h00;
    w_b_hi = 8'h00;
    unique case (r_op)
      OP_ADD_HL: begin
        w_b_lo = r_b[7:0];
        w_b_hi = r_b[15:8];
      end
      OP_ADD_SP: begin
        w_b_lo = r_b[7:0];
        w_b_hi = {8{r_b[7]}};
      end
      OP_INC16: begin
        w_b_lo = 8'h01;
        w_b_hi = 8'h00;
      end
      OP_DEC16: begin
        w_b_lo = 8'hFF;
        w_b_hi = 8'hFF;
      end
    endcase
  end

  always_comb begin
    w_flags_fin = r_fin;
    unique case (r_op)
      OP_ADD_HL:
        w_flags_fin = {r_fin[3], 1'b0,
                       i_alu_flags_from[1:0]};
      OP_ADD_SP:
        w_flags_fin = {2'b00, r_f_lo};
      default:
        w_flags_fin = r_fin;
    endcase
  end

  always_comb begin
    w_next         = r_state;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    o_alu_sel      = 1'b0;
    o_alu_a        = 8'h00;
    o_alu_b        = 8'h00;
    o_alu_op       = 5'd0;
    o_alu_flags_to = 4'h0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_LOW;
      end
      S_LOW: begin
        w_next    = S_HIGH;
        o_busy    = 1'b1;
        o_alu_sel = 1'b1;
        o_alu_a   = r_a[7:0];
        o_alu_b   = w_b_lo;
        o_alu_op  = OP_ADD;
      end
      S_HIGH: begin
        w_next         = S_DONE;
        o_busy         = 1'b1;
        o_alu_sel      = 1'b1;
        o_alu_a        = r_a[15:8];
        o_alu_b        = w_b_hi;
        o_alu_op       = OP_ADC;
        o_alu_flags_to = {3'b000, r_f_lo[0]};
      end
      S_DONE: begin
        w_next = S_IDLE;
        o_done = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'd0;
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_fin    <= 4'h0;
      r_res_lo <= 8'h00;
      r_f_lo   <= 2'b00;
      r_result <= 16'h0000;
      r_flags  <= 4'h0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op  <= i_op16;
            r_a   <= i_operand_a;
            r_b   <= i_operand_b;
            r_fin <= i_flags_in;
          end
        end
        S_LOW: begin
          r_res_lo <= i_alu_result;
          r_f_lo   <= i_alu_flags_from[1:0];
        end
        S_HIGH: begin
          r_result <= {i_alu_result, r_res_lo};
          r_flags  <= w_flags_fin;
        end
        default: ;
      endcase
    end
  end

  assign o_result16  = r_result;
  assign o_flags_out = r_flags;

endmodule
